// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher core.
//   - S-box / inverse S-box tables (byte 0 of each table in the MSBs)
//   - Rcon lookup, xtime/gmul GF(2^8) helpers, word helpers for key expansion
//   - inv_mix_column: one state column through InvMixColumns
//   - fsm_state_t: controller states (IDLE/ROUND/DONE)
//   - BLOCK_W: AES block width in bits
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Column bytes are row 0 (MSBs) to row 3 (LSBs).
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
//   state_in   : round input state, byte 0 in MSBs (column-major)
//   rk         : round key for this round
//   final_flag : 1 skips InvMixColumns (last round)
//   state_out  : round result
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] rk,
  input  logic               final_flag,
  output logic [BLOCK_W-1:0] state_out
);

  logic [BLOCK_W-1:0] sub_shift;
  logic [BLOCK_W-1:0] added;
  logic [BLOCK_W-1:0] mixed;

  always_comb begin
    sub_shift = '0;
    mixed     = '0;
    // Byte index is 4*col+row; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_shift[BLOCK_W-1-8*(4*c+r) -: 8] =
          INV_SBOX[state_in[BLOCK_W-1-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    added = sub_shift ^ rk;
    for (int c = 0; c < 4; c++) begin
      mixed[BLOCK_W-1-32*c -: 32] = inv_mix_column(added[BLOCK_W-1-32*c -: 32]);
    end
    state_out = final_flag ? added : mixed;
  end

endmodule

// File: rtl/aes_key_expansion.sv
// Combinational AES key schedule.
//   key        : cipher key, NK 32-bit words, word 0 in the MSBs
//   round_keys : NR+1 round keys; round key i sits at [128*i +: 128] with
//                word w[4i] in its MSBs
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic [32*NK-1:0]      key,
  output logic [128*(NR+1)-1:0] round_keys
);

  localparam int NW = 4 * (NR + 1);

  // Each word lives in its own generate scope so the w[j-1] -> w[j] chain
  // is a set of distinct nets rather than one self-referencing array.
  for (genvar j = 0; j < NW; j++) begin : g_w
    logic [31:0] w;
    if (j < NK) begin : g_key
      assign w = key[32*(NK-1-j) +: 32];
    end else if (j % NK == 0) begin : g_rot
      assign w = g_w[j-NK].w ^ sub_word(rot_word(g_w[j-1].w)) ^ {rcon(j / NK), 24'h000000};
    end else if (NK > 6 && j % NK == 4) begin : g_sub
      assign w = g_w[j-NK].w ^ sub_word(g_w[j-1].w);
    end else begin : g_cpy
      assign w = g_w[j-NK].w ^ g_w[j-1].w;
    end
    assign round_keys[128*(j/4) + 32*(3-(j%4)) +: 32] = w;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock.
//   NK         : key words (4/6/8 -> AES-128/192/256); NR derived
//   clk, reset : clock, asynchronous active-high reset
//   key_*      : key load handshake (key_in latched into the key register)
//   in_*       : ciphertext handshake
//   out_*      : plaintext handshake
//   busy       : high while a block is in ROUND or DONE
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// ready never depends on the same-channel valid; a producer holds valid and
// its data stable until the transfer edge.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int  NK = 4,
  localparam int NR = NK + 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [32*NK-1:0]   key_in,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
  end

  fsm_state_t             fsm_state;
  logic [32*NK-1:0]       key_reg;
  logic                   key_loaded;
  logic [3:0]             rnd;
  logic [BLOCK_W-1:0]     state_reg;
  logic [128*(NR+1)-1:0]  round_keys;
  logic [BLOCK_W-1:0]     rk_cur;
  logic [BLOCK_W-1:0]     round_out;
  logic                   key_fire;
  logic                   in_fire;

  aes_key_expansion #(.NK(NK), .NR(NR)) u_key_exp (
    .key        (key_reg),
    .round_keys (round_keys)
  );

  assign rk_cur = round_keys[{rnd, 7'd0} +: BLOCK_W];

  aes_inv_round u_round (
    .state_in   (state_reg),
    .rk         (rk_cur),
    .final_flag (rnd == 4'd0),
    .state_out  (round_out)
  );

  // Gated by reset so every output reads 0 while reset is held.
  assign key_ready = (fsm_state == IDLE) && !reset;
  // A simultaneous key offer takes priority over data.
  assign in_ready  = key_ready && key_loaded && !key_valid;
  assign key_fire  = key_valid && key_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (fsm_state == DONE);
  assign out_data  = out_valid ? state_reg : '0;
  assign busy      = (fsm_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state  <= IDLE;
      key_reg    <= '0;
      key_loaded <= 1'b0;
      rnd        <= '0;
      state_reg  <= '0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (key_fire) begin
            key_reg    <= key_in;
            key_loaded <= 1'b1;
          end else if (in_fire) begin
            state_reg <= in_data ^ round_keys[BLOCK_W*NR +: BLOCK_W];
            rnd       <= 4'(NR - 1);
            fsm_state <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          // The final round leaves rnd at 0 instead of wrapping.
          if (rnd == 4'd0) fsm_state <= DONE;
          else             rnd <= rnd - 4'd1;
        end
        DONE: begin
          if (out_ready) fsm_state <= IDLE;
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors across
// AES-128/192/256, handshake corner cases, back-pressure and reset abort.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] K6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C8  = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [127:0] key4 = '0, in4 = '0, od4;
  logic kv4 = 0, kr4, iv4 = 0, ir4, ov4, ordy4 = 0, busy4;
  logic [191:0] key6 = '0;
  logic [127:0] in6 = '0, od6;
  logic kv6 = 0, kr6, iv6 = 0, ir6, ov6, ordy6 = 0, busy6;
  logic [255:0] key8 = '0;
  logic [127:0] in8 = '0, od8;
  logic kv8 = 0, kr8, iv8 = 0, ir8, ov8, ordy8 = 0, busy8;

  aes_inv_cipher_iter #(.NK(4)) dut4 (
    .clk(clk), .reset(reset), .key_in(key4), .key_valid(kv4), .key_ready(kr4),
    .in_data(in4), .in_valid(iv4), .in_ready(ir4), .out_data(od4),
    .out_valid(ov4), .out_ready(ordy4), .busy(busy4));

  aes_inv_cipher_iter #(.NK(6)) dut6 (
    .clk(clk), .reset(reset), .key_in(key6), .key_valid(kv6), .key_ready(kr6),
    .in_data(in6), .in_valid(iv6), .in_ready(ir6), .out_data(od6),
    .out_valid(ov6), .out_ready(ordy6), .busy(busy6));

  aes_inv_cipher_iter #(.NK(8)) dut8 (
    .clk(clk), .reset(reset), .key_in(key8), .key_valid(kv8), .key_ready(kr8),
    .in_data(in8), .in_valid(iv8), .in_ready(ir8), .out_data(od8),
    .out_valid(ov8), .out_ready(ordy8), .busy(busy8));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key4(input logic [127:0] k);
    key4 = k;
    kv4  = 1'b1;
    checks++;
    if (kr4 !== 1'b1) begin
      errors++;
      $display("FAIL key_ready_load: got %b expected 1", kr4);
    end
    tick();
    kv4 = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid (bounded).
  task automatic wait_out4(output int lat);
    lat = 0;
    while (!ov4 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({kr4, ir4, ov4, busy4, od4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got kr=%b ir=%b ov=%b busy=%b od=%h expected all 0",
               kr4, ir4, ov4, busy4, od4);
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({kr4, ir4, ov4, busy4} !== 4'b1000) begin
      errors++;
      $display("FAIL after_reset: got kr/ir/ov/busy=%b expected 1000", {kr4, ir4, ov4, busy4});
    end
  endtask

  task automatic test_data_before_key();
    int lat;
    in4 = C1;
    iv4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ir4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL no_key_no_accept: got ir=%b busy=%b expected 0 0", ir4, busy4);
      end
    end
    key4 = K1;
    kv4  = 1'b1;
    checks++;
    if (ir4 !== 1'b0 || kr4 !== 1'b1) begin
      errors++;
      $display("FAIL key_wins: got ir=%b kr=%b expected 0 1", ir4, kr4);
    end
    tick();
    kv4 = 1'b0;
    #1;
    checks++;
    if (ir4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL data_next_cycle: got ir=%b busy=%b expected 1 0", ir4, busy4);
    end
    tick();
    iv4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || ov4 !== 1'b0 || od4 !== '0) begin
      errors++;
      $display("FAIL round_outputs: got busy=%b ov=%b od=%h expected 1 0 0", busy4, ov4, od4);
    end
    wait_out4(lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL latency_128: got %0d expected 10", lat);
    end
    checks++;
    if (od4 !== P1) begin
      errors++;
      $display("FAIL pt_fips_b: got %h expected %h", od4, P1);
    end
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || od4 !== '0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL release_1: got ov=%b od=%h busy=%b expected 0 0 0", ov4, od4, busy4);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    load_key4(K2);
    in4 = C2;
    iv4 = 1'b1;
    tick();
    wait_out4(lat);
    checks++;
    if (od4 !== P2) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", od4, P2);
    end
    // Second block is already offered; it may only be taken after IDLE returns.
    ordy4 = 1'b1;
    checks++;
    if (ir4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_accept_in_done: got ir=%b expected 0", ir4);
    end
    tick();
    ordy4 = 1'b0;
    checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_next: got ir=%b ov=%b expected 1 0", ir4, ov4);
    end
    tick();
    iv4 = 1'b0;
    wait_out4(lat);
    checks++;
    if (od4 !== P2 || lat !== 10) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected %h lat 10", od4, lat, P2);
    end
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    in4 = C2;
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    wait_out4(lat);
    // An offered key during DONE must be ignored.
    key4 = 128'hdeadbeef_00000000_11111111_22222222;
    kv4  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (od4 !== P2 || ov4 !== 1'b1 || ir4 !== 1'b0 || kr4 !== 1'b0 || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: got od=%h ov=%b ir=%b kr=%b busy=%b expected %h 1 0 0 1",
                 i, od4, ov4, ir4, kr4, busy4, P2);
      end
    end
    kv4   = 1'b0;
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || od4 !== '0) begin
      errors++;
      $display("FAIL hold_release: got ov=%b od=%h expected 0 0", ov4, od4);
    end
    in4 = C2;
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    wait_out4(lat);
    checks++;
    if (od4 !== P2) begin
      errors++;
      $display("FAIL key_kept: got %h expected %h", od4, P2);
    end
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat;
    load_key4(K1);
    in4 = C1;
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 1", busy4);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({kr4, ir4, ov4, busy4, od4} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got kr=%b ir=%b ov=%b busy=%b od=%h expected all 0",
               kr4, ir4, ov4, busy4, od4);
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
    in4 = C1;
    iv4 = 1'b1;
    #1;
    checks++;
    if (ir4 !== 1'b0 || kr4 !== 1'b1) begin
      errors++;
      $display("FAIL abort_key_lost: got ir=%b kr=%b expected 0 1", ir4, kr4);
    end
    iv4 = 1'b0;
    tick();
    load_key4(K1);
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    wait_out4(lat);
    checks++;
    if (od4 !== P1 || lat !== 10) begin
      errors++;
      $display("FAIL abort_recover: got %h lat %0d expected %h lat 10", od4, lat, P1);
    end
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
  endtask

  task automatic test_aes192();
    int lat;
    key6 = K6;
    kv6  = 1'b1;
    tick();
    kv6 = 1'b0;
    in6 = C6;
    iv6 = 1'b1;
    #1;
    checks++;
    if (ir6 !== 1'b1) begin
      errors++;
      $display("FAIL ready_192: got %b expected 1", ir6);
    end
    tick();
    iv6 = 1'b0;
    lat = 0;
    while (!ov6 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (od6 !== P2 || lat !== 12) begin
      errors++;
      $display("FAIL pt_192: got %h lat %0d expected %h lat 12", od6, lat, P2);
    end
    ordy6 = 1'b1;
    tick();
    ordy6 = 1'b0;
  endtask

  task automatic test_aes256();
    int lat;
    key8 = K8;
    kv8  = 1'b1;
    tick();
    kv8 = 1'b0;
    in8 = C8;
    iv8 = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL ready_256: got %b expected 1", ir8);
    end
    tick();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (od8 !== P2 || lat !== 14) begin
      errors++;
      $display("FAIL pt_256: got %h lat %0d expected %h lat 14", od8, lat, P2);
    end
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_data_before_key();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_aes192();
    test_aes256();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
